dmem_lsu: RTL and testbench

//  Parametrised data memory with an integrated load/store front end.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_bank.sv | 28 ++
 rtl/dmem_lsu.sv | 151 +++++++++++++++
 tb/tb_dmem_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the dmem load/store unit.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic {CLEAR, RUN} state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x DATA_W synchronous RAM, per-byte write enables, registered read.
module dmem_bank #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   localparam int BYTES = DATA_W / 8,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BYTES-1:0]  be,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with load/store front end: alignment/range checks, byte lanes,
// sign/zero extension and a post-reset clear sweep.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFS   = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [32:0]       LIMIT = 33'(DEPTH * BYTES);
   localparam logic [DATA_W-1:0] ONES  = '1;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;

   logic              acc, err, size_err, mis_err, rng_err;
   logic [3:0]        nb;
   logic [OFS-1:0]    lane;
   logic [IDX_W-1:0]  widx;
   logic [BYTES-1:0]  st_be;

   logic              b_we, b_re;
   logic [BYTES-1:0]  b_be;
   logic [IDX_W-1:0]  b_idx;
   logic [DATA_W-1:0] b_wdata, b_rdata;

   logic              ld_q, uns_q;
   logic [1:0]        size_q;
   logic [OFS-1:0]    lane_q;

   logic [DATA_W-1:0] sh, keep, ext;
   logic              sign;

   assign req_ready = (state_q == RUN);
   assign init_done = (state_q == RUN);
   assign acc       = req_valid & req_ready;

   assign nb       = size_bytes(req_size);
   assign lane     = req_addr[OFS-1:0];
   assign widx     = req_addr[OFS+IDX_W-1:OFS];
   assign size_err = (DATA_W == 32) && (req_size == SZ_D);
   assign mis_err  = |(req_addr[3:0] & (nb - 4'd1));
   assign rng_err  = ({1'b0, req_addr} >= LIMIT);
   assign err      = size_err | mis_err | rng_err;

   always_comb begin
      st_be = '0;
      for (int unsigned b = 0; b < BYTES; b++) begin
         st_be[b] = (b >= 32'(lane)) && (b < 32'(lane) + 32'(nb));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      b_we    = 1'b0;
      b_re    = 1'b0;
      b_be    = '0;
      b_idx   = widx;
      b_wdata = req_wdata << {lane, 3'b000};
      case (state_q)
         CLEAR: begin
            b_we    = 1'b1;
            b_be    = '1;
            b_idx   = cnt_q;
            b_wdata = '0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
         end
         default: begin
            b_we = acc & req_we & ~err;
            b_re = acc & ~req_we & ~err;
            b_be = st_be;
         end
      endcase
   end

   dmem_bank #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_bank (
      .clk  (clk),
      .we   (b_we),
      .be   (b_be),
      .re   (b_re),
      .idx  (b_idx),
      .wdata(b_wdata),
      .rdata(b_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         ld_q      <= 1'b0;
         uns_q     <= 1'b0;
         size_q    <= SZ_B;
         lane_q    <= '0;
      end else begin
         rsp_valid <= acc;
         rsp_err   <= acc & err;
         ld_q      <= acc & ~req_we & ~err;
         uns_q     <= req_unsigned;
         size_q    <= req_size;
         lane_q    <= lane;
      end
   end

   // Bank read data is only meaningful when ld_q is set; otherwise force zero.
   always_comb begin
      sh   = b_rdata >> {lane_q, 3'b000};
      keep = '1;
      if (32'(size_bytes(size_q)) * 8 < DATA_W) keep = ~(ONES << (32'(size_bytes(size_q)) * 8));
      case (size_q)
         SZ_B:    sign = sh[7];
         SZ_H:    sign = sh[15];
         SZ_W:    sign = sh[31];
         default: sign = sh[DATA_W-1];
      endcase
      ext       = (sh & keep) | ((sign & ~uns_q) ? ~keep : '0);
      rsp_rdata = ld_q ? ext : '0;
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: 32-bit and 64-bit instances side by side.
module tb_dmem_lsu;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v32 = 1'b0, v64 = 1'b0;
   logic        we = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0;

   logic        r32_ready, r32_valid, r32_err, r32_done;
   logic [31:0] r32_rdata;
   logic        r64_ready, r64_valid, r64_err, r64_done;
   logic [63:0] r64_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (
      .clk(clk), .rst(rst), .req_valid(v32), .req_ready(r32_ready), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata[31:0]),
      .rsp_valid(r32_valid), .rsp_rdata(r32_rdata), .rsp_err(r32_err), .init_done(r32_done)
   );

   dmem_lsu #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (
      .clk(clk), .rst(rst), .req_valid(v64), .req_ready(r64_ready), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .rsp_valid(r64_valid), .rsp_rdata(r64_rdata), .rsp_err(r64_err), .init_done(r64_done)
   );

   typedef struct {
      bit          w64;
      bit          we;
      logic [1:0]  size;
      bit          uns;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      bit          exp_err;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input bit w64, input bit w, input logic [1:0] sz, input bit u,
                      input logic [31:0] a, input logic [63:0] wd, input logic [63:0] er,
                      input bit ee, input string n);
      vec_t t;
      t.w64 = w64; t.we = w; t.size = sz; t.uns = u; t.addr = a;
      t.wdata = wd; t.exp_rdata = er; t.exp_err = ee; t.name = n;
      vecs.push_back(t);
   endtask

   task automatic do_req(input vec_t t);
      @(negedge clk);
      we = t.we; size = t.size; uns = t.uns; addr = t.addr; wdata = t.wdata;
      if (t.w64) v64 = 1'b1; else v32 = 1'b1;
      @(posedge clk);
      #1;
      v32 = 1'b0; v64 = 1'b0;
      chk({t.name, ".valid"}, {63'd0, t.w64 ? r64_valid : r32_valid}, 64'd1);
      chk({t.name, ".rdata"}, t.w64 ? r64_rdata : {32'd0, r32_rdata}, t.exp_rdata);
      chk({t.name, ".err"}, {63'd0, t.w64 ? r64_err : r32_err}, {63'd0, t.exp_err});
   endtask

   // Counts edges from reset release to init_done; flags any response or early ready.
   task automatic wait_init(input string name);
      int n = 0, pulses = 0, bad = 0;
      while (!(r32_done && r64_done) && n < 2 * DEPTH) begin
         @(posedge clk);
         #1;
         n++;
         if (r32_valid || r64_valid) pulses++;
         if ((!r32_done && r32_ready) || (!r64_done && r64_ready)) bad++;
      end
      v32 = 1'b0; v64 = 1'b0;
      chk({name, ".init_cycles"}, 64'(n), 64'(DEPTH));
      chk({name, ".both_done"}, {62'd0, r32_done, r64_done}, 64'd3);
      chk({name, ".no_rsp"}, 64'(pulses), 64'd0);
      chk({name, ".ready_early"}, 64'(bad), 64'd0);
   endtask

   initial begin
      // 32-bit instance
      add(0, 0, 2'b10, 0, 32'h10,  '0, 64'h0, 0, "lw_cleared");
      add(0, 0, 2'b10, 0, 32'h3FC, '0, 64'h0, 0, "lw_top_cleared");
      add(0, 1, 2'b10, 0, 32'h10,  64'h8000_00F1, 64'h0, 0, "sw_10");
      add(0, 0, 2'b00, 0, 32'h10,  '0, 64'hFFFF_FFF1, 0, "lb_10");
      add(0, 0, 2'b00, 1, 32'h10,  '0, 64'h0000_00F1, 0, "lbu_10");
      add(0, 0, 2'b01, 0, 32'h12,  '0, 64'hFFFF_8000, 0, "lh_12");
      add(0, 0, 2'b01, 1, 32'h12,  '0, 64'h0000_8000, 0, "lhu_12");
      add(0, 1, 2'b10, 0, 32'h20,  64'h1122_3344, 64'h0, 0, "sw_20");
      add(0, 1, 2'b00, 0, 32'h21,  64'h0000_00AA, 64'h0, 0, "sb_21");
      add(0, 0, 2'b10, 0, 32'h20,  '0, 64'h1122_AA44, 0, "lw_20");
      add(0, 0, 2'b00, 1, 32'h23,  '0, 64'h11, 0, "lbu_23");
      add(0, 0, 2'b10, 0, 32'h22,  '0, 64'h0, 1, "lw_22_mis");
      add(0, 1, 2'b01, 0, 32'h05,  64'hFFFF, 64'h0, 1, "sh_05_mis");
      add(0, 0, 2'b10, 0, 32'h04,  '0, 64'h0, 0, "lw_04_intact");
      add(0, 0, 2'b10, 0, 32'h20,  '0, 64'h1122_AA44, 0, "lw_20_intact");
      add(0, 0, 2'b10, 0, 32'h400, '0, 64'h0, 1, "lw_400_range");
      add(0, 1, 2'b11, 0, 32'h00,  64'h1, 64'h0, 1, "sd_illegal32");
      add(0, 0, 2'b10, 0, 32'h00,  '0, 64'h0, 0, "lw_00_intact");
      add(0, 1, 2'b10, 0, 32'h3FC, 64'hCAFE_F00D, 64'h0, 0, "sw_3fc");
      add(0, 0, 2'b00, 0, 32'h3FF, '0, 64'hFFFF_FFCA, 0, "lb_3ff");
      add(0, 0, 2'b01, 1, 32'h3FE, '0, 64'h0000_CAFE, 0, "lhu_3fe");
      // 64-bit instance
      add(1, 0, 2'b11, 0, 32'h10,  '0, 64'h0, 0, "ld_cleared");
      add(1, 1, 2'b11, 0, 32'h10,  64'h8000_0000_0000_00F1, 64'h0, 0, "sd_10");
      add(1, 0, 2'b00, 0, 32'h10,  '0, 64'hFFFF_FFFF_FFFF_FFF1, 0, "lb64_10");
      add(1, 0, 2'b00, 1, 32'h10,  '0, 64'h0000_0000_0000_00F1, 0, "lbu64_10");
      add(1, 0, 2'b01, 0, 32'h16,  '0, 64'hFFFF_FFFF_FFFF_8000, 0, "lh64_16");
      add(1, 0, 2'b10, 0, 32'h14,  '0, 64'hFFFF_FFFF_8000_0000, 0, "lw64_14");
      add(1, 0, 2'b10, 1, 32'h14,  '0, 64'h0000_0000_8000_0000, 0, "lwu64_14");
      add(1, 1, 2'b11, 0, 32'h20,  64'h1122_3344_5566_7788, 64'h0, 0, "sd_20");
      add(1, 1, 2'b00, 0, 32'h21,  64'hAA, 64'h0, 0, "sb64_21");
      add(1, 0, 2'b11, 0, 32'h20,  '0, 64'h1122_3344_5566_AA88, 0, "ld_20");
      add(1, 0, 2'b10, 1, 32'h24,  '0, 64'h0000_0000_1122_3344, 0, "lwu64_24");
      add(1, 0, 2'b11, 0, 32'h24,  '0, 64'h0, 1, "ld_24_mis");
      add(1, 0, 2'b10, 0, 32'h22,  '0, 64'h0, 1, "lw64_22_mis");
      add(1, 1, 2'b01, 0, 32'h05,  64'hFFFF, 64'h0, 1, "sh64_05_mis");
      add(1, 0, 2'b11, 0, 32'h00,  '0, 64'h0, 0, "ld_00_intact");
      add(1, 0, 2'b11, 0, 32'h800, '0, 64'h0, 1, "ld_800_range");
      add(1, 0, 2'b11, 0, 32'h7F8, '0, 64'h0, 0, "ld_7f8_ok");
      add(1, 0, 2'b11, 0, 32'h20,  '0, 64'h1122_3344_5566_AA88, 0, "ld_20_intact");

      // Reset values, then sweep with a request held that must be ignored
      repeat (2) @(posedge clk);
      #1;
      chk("rst.outs32", {r32_ready, r32_valid, r32_err, r32_done, r32_rdata}, '0);
      chk("rst.outs64", {r64_ready, r64_valid, r64_err, r64_done, r64_rdata[59:0]}, '0);
      @(negedge clk);
      we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      v32 = 1'b1; v64 = 1'b1;
      rst = 1'b0;
      wait_init("init1");

      foreach (vecs[i]) do_req(vecs[i]);

      // Back-to-back store then load
      @(negedge clk);
      we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 64'hDEAD_BEEF; v32 = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b.rsp1_valid", {63'd0, r32_valid}, 64'd1);
      chk("b2b.rsp1_rdata", {32'd0, r32_rdata}, 64'd0);
      we = 1'b0;
      @(posedge clk);
      #1;
      v32 = 1'b0;
      chk("b2b.rsp2_valid", {63'd0, r32_valid}, 64'd1);
      chk("b2b.rsp2_rdata", {32'd0, r32_rdata}, 64'hDEAD_BEEF);
      @(posedge clk);
      #1;
      chk("b2b.idle_valid", {63'd0, r32_valid}, 64'd0);

      // Reset with a load response pending, then a second reset mid-sweep
      @(negedge clk);
      we = 1'b0; size = 2'b10; addr = 32'h40; v32 = 1'b1;
      @(posedge clk);
      rst = 1'b1;
      v32 = 1'b0;
      #1;
      chk("rst_pend.valid", {63'd0, r32_valid}, 64'd0);
      chk("rst_pend.ready", {62'd0, r32_ready, r32_done}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (r32_valid || r64_valid || r32_done) chk("midsweep.quiet", 64'd1, 64'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_init("init2");
      do_req('{0, 0, 2'b10, 0, 32'h40, '0, 64'h0, 0, "lw_40_recleared"});
      do_req('{1, 0, 2'b11, 0, 32'h20, '0, 64'h0, 0, "ld_20_recleared"});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
